// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding read at a time,
// and buffers returned words in a 2-entry prefetch FIFO ahead of the IF/ID register.
//
// state      | meaning
// FETCH      | request at req_pc, push returned word
// FULL       | FIFO full, no request until a pop
// DRAIN      | wait out a wrong-path request, then refetch at fetch_pc
// HALT_DRAIN | wait out the last request before halting
// HALTED     | idle until reset
module if_fetch_unit #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter int                   BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 i_mem_req,
  output logic [WORD_SIZE-1:0] i_mem_addr,
  input  logic                 i_mem_ack,
  input  logic [WORD_SIZE-1:0] i_mem_data,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 halt,
  output logic                 if_valid,
  output logic [WORD_SIZE-1:0] IF_instr,
  output logic [WORD_SIZE-1:0] IF_current_pc,
  output logic [WORD_SIZE-1:0] IF_PC_plus_one,
  output logic [WORD_SIZE-1:0] fetch_count
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_FULL,
    S_DRAIN,
    S_HALT_DRAIN,
    S_HALTED
  } state_t;

  localparam logic [WORD_SIZE-1:0] ONE  = 1;
  localparam logic [1:0]           FULL = BUF_DEPTH[1:0];

  state_t               state;
  logic [WORD_SIZE-1:0] fetch_pc;
  logic [WORD_SIZE-1:0] req_pc;
  logic [WORD_SIZE-1:0] e0_instr, e0_pc, e1_instr, e1_pc;
  logic [1:0]           count;
  logic [1:0]           count_after;
  logic                 head_valid, flush, pop, push;

  assign head_valid = (count != 2'd0);
  assign flush      = halt | redirect_valid;
  assign pop        = head_valid & ~stall & ~flush;
  assign push       = (state == S_FETCH) & i_mem_ack & ~flush & (count != FULL);

  always_comb begin
    count_after = count;
    case ({push, pop})
      2'b10:   count_after = count + 2'd1;
      2'b01:   count_after = count - 2'd1;
      default: count_after = count;
    endcase
  end

  assign i_mem_req      = reset_n & (state inside {S_FETCH, S_DRAIN, S_HALT_DRAIN});
  assign i_mem_addr     = req_pc;
  assign if_valid       = head_valid;
  assign IF_instr       = head_valid ? e0_instr : '0;
  assign IF_current_pc  = head_valid ? e0_pc : '0;
  assign IF_PC_plus_one = head_valid ? (e0_pc + ONE) : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_FETCH;
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      count       <= 2'd0;
      e0_instr    <= '0;
      e0_pc       <= '0;
      e1_instr    <= '0;
      e1_pc       <= '0;
      fetch_count <= '0;
    end else begin
      if (flush) begin
        count <= 2'd0;
      end else begin
        count <= count_after;
        if (pop) begin
          e0_instr <= e1_instr;
          e0_pc    <= e1_pc;
        end
        // A push that coincides with popping the only entry lands at the head.
        if (push) begin
          if (count == 2'd0 || pop) begin
            e0_instr <= i_mem_data;
            e0_pc    <= req_pc;
          end else begin
            e1_instr <= i_mem_data;
            e1_pc    <= req_pc;
          end
          fetch_count <= fetch_count + ONE;
        end
      end

      case (state)
        S_FETCH: begin
          if (halt) begin
            state <= i_mem_ack ? S_HALTED : S_HALT_DRAIN;
          end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            if (i_mem_ack) req_pc <= redirect_pc;
            else           state  <= S_DRAIN;
          end else if (i_mem_ack) begin
            fetch_pc <= fetch_pc + ONE;
            req_pc   <= fetch_pc + ONE;
            if (count_after == FULL) state <= S_FULL;
          end
        end
        S_FULL: begin
          if (halt) begin
            state <= S_HALTED;
          end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            req_pc   <= redirect_pc;
            state    <= S_FETCH;
          end else if (pop) begin
            state <= S_FETCH;
          end
        end
        // fetch_pc holds the pending redirect target while the stale request drains.
        S_DRAIN: begin
          if (halt) begin
            state <= i_mem_ack ? S_HALTED : S_HALT_DRAIN;
          end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            if (i_mem_ack) begin
              req_pc <= redirect_pc;
              state  <= S_FETCH;
            end
          end else if (i_mem_ack) begin
            req_pc <= fetch_pc;
            state  <= S_FETCH;
          end
        end
        S_HALT_DRAIN: begin
          if (i_mem_ack) state <= S_HALTED;
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a vector table for fill/stall/pop behaviour plus
// hand-written redirect, halt and PC-wrap sequences against a latency-programmable memory.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_mem_req;
  logic [15:0] i_mem_addr;
  logic        i_mem_ack;
  logic [15:0] i_mem_data;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt = 1'b0;
  logic        if_valid;
  logic [15:0] IF_instr, IF_current_pc, IF_PC_plus_one, fetch_count;

  int n_cmp = 0;
  int n_bad = 0;
  int mem_lat = 0;
  int wait_cnt = 0;

  if_fetch_unit dut (
    .clk(clk), .reset_n(reset_n),
    .i_mem_req(i_mem_req), .i_mem_addr(i_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .if_valid(if_valid), .IF_instr(IF_instr),
    .IF_current_pc(IF_current_pc), .IF_PC_plus_one(IF_PC_plus_one),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Memory: acks after mem_lat wait cycles; word content is address + 0x1234.
  assign i_mem_ack  = i_mem_req && (wait_cnt >= mem_lat);
  assign i_mem_data = i_mem_addr + 16'h1234;
  always @(posedge clk)
    if (!reset_n || !i_mem_req || i_mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int lat);
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; halt = 1'b0;
    redirect_pc = 16'h0000; mem_lat = lat;
    repeat (2) cyc();
    chk("reset_req", {15'd0, i_mem_req}, 16'd0);
    reset_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic        stall;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] cur;
    logic [15:0] pc1;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Row i: outputs expected in cycle i after reset release, and stall driven in that cycle.
    tbl[0] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'd0};
    tbl[1] = '{1'b1, 1'b1, 16'h0001, 1'b1, 16'h1234, 16'h0000, 16'h0001, 16'd1};
    tbl[2] = '{1'b1, 1'b0, 16'h0002, 1'b1, 16'h1234, 16'h0000, 16'h0001, 16'd2};
    tbl[3] = '{1'b0, 1'b0, 16'h0002, 1'b1, 16'h1234, 16'h0000, 16'h0001, 16'd2};
    tbl[4] = '{1'b1, 1'b1, 16'h0002, 1'b1, 16'h1235, 16'h0001, 16'h0002, 16'd2};
    tbl[5] = '{1'b0, 1'b0, 16'h0003, 1'b1, 16'h1235, 16'h0001, 16'h0002, 16'd3};
    tbl[6] = '{1'b0, 1'b1, 16'h0003, 1'b1, 16'h1236, 16'h0002, 16'h0003, 16'd3};
    tbl[7] = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'h1237, 16'h0003, 16'h0004, 16'd4};

    do_reset(0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tbl%0d_req", i),   {15'd0, i_mem_req}, {15'd0, tbl[i].req});
      chk($sformatf("tbl%0d_addr", i),  i_mem_addr,         tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), {15'd0, if_valid},  {15'd0, tbl[i].valid});
      chk($sformatf("tbl%0d_instr", i), IF_instr,           tbl[i].instr);
      chk($sformatf("tbl%0d_pc", i),    IF_current_pc,      tbl[i].cur);
      chk($sformatf("tbl%0d_pc1", i),   IF_PC_plus_one,     tbl[i].pc1);
      chk($sformatf("tbl%0d_fc", i),    fetch_count,        tbl[i].fc);
      stall = tbl[i].stall;
      cyc();
    end

    // Redirect while a 3-wait-cycle request is outstanding.
    do_reset(3);
    chk("rdw_addr0", i_mem_addr, 16'h0000);
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    cyc();
    redirect_valid = 1'b0;
    chk("rdw_valid", {15'd0, if_valid}, 16'd0);
    for (int k = 0; k < 10 && !i_mem_ack; k++) begin
      chk("rdw_hold_addr", i_mem_addr, 16'h0000);
      chk("rdw_hold_req", {15'd0, i_mem_req}, 16'd1);
      cyc();
    end
    chk("rdw_ack_seen", {15'd0, i_mem_ack}, 16'd1);
    chk("rdw_ack_addr", i_mem_addr, 16'h0000);
    cyc();
    chk("rdw_new_addr", i_mem_addr, 16'h0040);
    chk("rdw_discard_valid", {15'd0, if_valid}, 16'd0);
    chk("rdw_discard_fc", fetch_count, 16'd0);
    for (int k = 0; k < 20 && !if_valid; k++) cyc();
    chk("rdw_first_valid", {15'd0, if_valid}, 16'd1);
    chk("rdw_first_pc", IF_current_pc, 16'h0040);
    chk("rdw_first_instr", IF_instr, 16'h1274);
    chk("rdw_first_pc1", IF_PC_plus_one, 16'h0041);
    chk("rdw_first_fc", fetch_count, 16'd1);

    // Redirect on the same cycle as a zero-latency ack.
    do_reset(0);
    chk("rda_ack", {15'd0, i_mem_ack}, 16'd1);
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    cyc();
    redirect_valid = 1'b0;
    chk("rda_valid", {15'd0, if_valid}, 16'd0);
    chk("rda_instr", IF_instr, 16'h0000);
    chk("rda_addr", i_mem_addr, 16'h0100);
    chk("rda_req", {15'd0, i_mem_req}, 16'd1);
    chk("rda_fc", fetch_count, 16'd0);
    cyc();
    chk("rda_next_valid", {15'd0, if_valid}, 16'd1);
    chk("rda_next_pc", IF_current_pc, 16'h0100);
    chk("rda_next_instr", IF_instr, 16'h1334);

    // Halt with one entry buffered and a request outstanding.
    do_reset(1);
    cyc();
    cyc();
    chk("hlt_pre_valid", {15'd0, if_valid}, 16'd1);
    chk("hlt_pre_addr", i_mem_addr, 16'h0001);
    chk("hlt_pre_ack", {15'd0, i_mem_ack}, 16'd0);
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    chk("hlt_flush_valid", {15'd0, if_valid}, 16'd0);
    chk("hlt_flush_instr", IF_instr, 16'h0000);
    chk("hlt_drain_req", {15'd0, i_mem_req}, 16'd1);
    chk("hlt_drain_addr", i_mem_addr, 16'h0001);
    for (int k = 0; k < 10 && !i_mem_ack; k++) cyc();
    chk("hlt_drain_ack", {15'd0, i_mem_ack}, 16'd1);
    for (int k = 0; k < 8; k++) begin
      cyc();
      redirect_valid = k[0];
      redirect_pc = 16'h0200;
      chk("hlt_req_off", {15'd0, i_mem_req}, 16'd0);
      chk("hlt_valid_off", {15'd0, if_valid}, 16'd0);
      chk("hlt_fc_frozen", fetch_count, 16'd1);
    end
    redirect_valid = 1'b0;

    // PC wrap from 0xFFFF to 0x0000 with both words buffered under stall.
    do_reset(0);
    stall = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    cyc();
    redirect_valid = 1'b0;
    chk("wrap_addr_ffff", i_mem_addr, 16'hFFFF);
    chk("wrap_empty", {15'd0, if_valid}, 16'd0);
    cyc();
    chk("wrap_head_pc", IF_current_pc, 16'hFFFF);
    chk("wrap_head_pc1", IF_PC_plus_one, 16'h0000);
    chk("wrap_head_instr", IF_instr, 16'h1233);
    chk("wrap_next_addr", i_mem_addr, 16'h0000);
    cyc();
    chk("wrap_full_req", {15'd0, i_mem_req}, 16'd0);
    stall = 1'b0;
    cyc();
    chk("wrap_pop_pc", IF_current_pc, 16'h0000);
    chk("wrap_pop_pc1", IF_PC_plus_one, 16'h0001);
    chk("wrap_pop_instr", IF_instr, 16'h1234);
    chk("wrap_fc", fetch_count, 16'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
